// File: rtl/dds_phase_lane_gen.sv
// DDS phase lane generator: 3-stage pipeline from DDS parameters to an AXI-Stream beat of
// LANES consecutive phase words, with a continuous 48-bit phase accumulator.
module dds_phase_lane_gen #(
    parameter int LANES           = 16,
    parameter int PHASE_OUT_WIDTH = 16,
    parameter int AXIS_DATA_WIDTH = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [47:0]                freq,
    input  logic [13:0]                phase,
    input  logic [13:0]                amp,
    input  logic [13:0]                amp_offset,
    input  logic                       out_en,
    input  logic                       phase_clr,
    input  logic                       m_axis_data_tready,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_data_tdata,
    output logic                       m_axis_data_tvalid,
    output logic [13:0]                amp_out,
    output logic [13:0]                amp_offset_out
);

    localparam int LOG2_LANES = $clog2(LANES);

    if (AXIS_DATA_WIDTH != LANES * PHASE_OUT_WIDTH) begin : g_bad_width
        $error("dds_phase_lane_gen: AXIS_DATA_WIDTH must equal LANES*PHASE_OUT_WIDTH");
    end
    if (LANES < 2 || LANES > 16 || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
        $error("dds_phase_lane_gen: LANES must be a power of 2 in 2..16");
    end
    if (PHASE_OUT_WIDTH < 1 || PHASE_OUT_WIDTH > 48) begin : g_bad_pow
        $error("dds_phase_lane_gen: PHASE_OUT_WIDTH must be 1..48");
    end

    // S0: input capture
    logic [47:0] freq0_q;
    logic [13:0] phase0_q;
    logic [13:0] amp0_q;
    logic [13:0] amp_off0_q;
    logic        clr0_q;
    logic        v0_q;

    // S1: accumulator and beat base
    logic [47:0] acc_q;
    logic [47:0] acc_d;
    logic [47:0] base1_q;
    logic [47:0] base1_d;
    logic [47:0] freq1_q;
    logic [13:0] amp1_q;
    logic [13:0] amp_off1_q;
    logic        v1_q;

    // S2: output beat
    logic [AXIS_DATA_WIDTH-1:0] tdata_q;
    logic [AXIS_DATA_WIDTH-1:0] tdata_d;
    logic                       tvalid_q;
    logic [13:0]                amp2_q;
    logic [13:0]                amp_off2_q;

    logic adv;
    logic lane_lsbs_unused;

    assign adv = !tvalid_q || m_axis_data_tready;

    always_comb begin
        logic [47:0] start;
        start   = clr0_q ? 48'd0 : acc_q;
        base1_d = start + {phase0_q, 34'd0};
        acc_d   = start + (freq0_q << LOG2_LANES);
    end

    // k*freq is the sum of freq shifted by each set bit of k; no multiplier needed.
    always_comb begin
        logic [47:0] step;
        logic [47:0] lane;
        tdata_d          = '0;
        lane_lsbs_unused = 1'b0;
        step             = '0;
        lane             = '0;
        for (int k = 0; k < LANES; k++) begin
            step = '0;
            for (int b = 0; b < LOG2_LANES; b++) begin
                if (((k >> b) & 1) != 0) begin
                    step = step + (freq1_q << b);
                end
            end
            lane = base1_q + step;
            tdata_d[k*PHASE_OUT_WIDTH +: PHASE_OUT_WIDTH] = lane[47 -: PHASE_OUT_WIDTH];
            lane_lsbs_unused ^= ^lane;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            freq0_q    <= '0;
            phase0_q   <= '0;
            amp0_q     <= '0;
            amp_off0_q <= '0;
            clr0_q     <= 1'b0;
            v0_q       <= 1'b0;
            acc_q      <= '0;
            base1_q    <= '0;
            freq1_q    <= '0;
            amp1_q     <= '0;
            amp_off1_q <= '0;
            v1_q       <= 1'b0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            amp2_q     <= '0;
            amp_off2_q <= '0;
        end else if (adv) begin
            freq0_q    <= freq;
            phase0_q   <= phase;
            amp0_q     <= amp;
            amp_off0_q <= amp_offset;
            clr0_q     <= phase_clr;
            v0_q       <= out_en;

            // Bubbles leave the accumulator untouched so phase stays continuous.
            if (v0_q) begin
                acc_q   <= acc_d;
                base1_q <= base1_d;
                freq1_q <= freq0_q;
            end
            v1_q       <= v0_q;
            amp1_q     <= amp0_q;
            amp_off1_q <= amp_off0_q;

            tdata_q    <= tdata_d;
            tvalid_q   <= v1_q;
            amp2_q     <= amp1_q;
            amp_off2_q <= amp_off1_q;
        end
    end

    assign m_axis_data_tdata  = tdata_q;
    assign m_axis_data_tvalid = tvalid_q;
    assign amp_out            = amp2_q;
    assign amp_offset_out     = amp_off2_q;

endmodule
